// File: rtl/mem_noc_responder.sv
// mem_noc_responder: memory-side NoC endpoint. Accepts 39-bit request packets
// over a 4-phase bundled-data channel, serves writes/reads against a local
// word store, and returns read-response packets on a second 4-phase channel.
module mem_noc_responder #(
  parameter logic [3:0]  NODE_ID = 4'd0,
  parameter int unsigned DEPTH   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_req,
  input  logic [38:0] in_data,
  output logic        in_ack,
  output logic        out_req,
  output logic [38:0] out_data,
  input  logic        out_ack,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, IN_REL, EXEC, RESP, RESP_REL} state_t;

  state_t      state;
  logic        in_req_m, in_req_s;
  logic        out_ack_m, out_ack_s;
  logic [38:0] pkt;
  logic [15:0] mem [DEPTH];

  logic [3:0]    pkt_dst;
  logic [3:0]    pkt_src;
  logic [1:0]    pkt_op;
  logic [12:0]   pkt_addr;
  logic [15:0]   pkt_data;
  logic [AW-1:0] idx;
  logic          addr_ok;
  logic          reject;
  logic          is_write;
  logic          is_read;
  logic [15:0]   rd_word;

  // Two-flop synchronizers for the asynchronous handshake inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_req_m  <= 1'b0;
      in_req_s  <= 1'b0;
      out_ack_m <= 1'b0;
      out_ack_s <= 1'b0;
    end else begin
      in_req_m  <= in_req;
      in_req_s  <= in_req_m;
      out_ack_m <= out_ack;
      out_ack_s <= out_ack_m;
    end
  end

  // Field decode and request classification of the latched packet
  always_comb begin
    pkt_dst  = pkt[38:35];
    pkt_src  = pkt[34:31];
    pkt_op   = pkt[30:29];
    pkt_addr = pkt[28:16];
    pkt_data = pkt[15:0];
    idx      = pkt_addr[AW-1:0];
    addr_ok  = ({19'd0, pkt_addr} < DEPTH);
    reject   = (pkt_dst != NODE_ID) || pkt_op[1] || !addr_ok;
    is_write = !reject && (pkt_op == 2'b00);
    is_read  = !reject && (pkt_op == 2'b01);
    rd_word  = mem[idx];
  end

  // Local word store, cleared by reset, written only from EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == EXEC && is_write) begin
      mem[idx] <= pkt_data;
    end
  end

  // Handshake/execute FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pkt      <= '0;
      in_ack   <= 1'b0;
      out_req  <= 1'b0;
      out_data <= '0;
      err_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_req_s) begin
            pkt    <= in_data;
            in_ack <= 1'b1;
            busy   <= 1'b1;
            state  <= IN_REL;
          end
        end
        IN_REL: begin
          if (!in_req_s) begin
            in_ack <= 1'b0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (is_read) begin
            out_data <= {pkt_src, NODE_ID, 2'b10, pkt_addr, rd_word};
            out_req  <= 1'b1;
            state    <= RESP;
          end else begin
            if (reject && err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RESP: begin
          if (out_ack_s) begin
            out_req <= 1'b0;
            state   <= RESP_REL;
          end
        end
        RESP_REL: begin
          if (!out_ack_s) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_noc_responder.sv
// tb_mem_noc_responder: directed-vector bench for mem_noc_responder (NODE_ID=3).
module tb_mem_noc_responder;

  logic        clk;
  logic        rst_n;
  logic        in_req;
  logic [38:0] in_data;
  logic        in_ack;
  logic        out_req;
  logic [38:0] out_data;
  logic        out_ack;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mem_noc_responder #(.NODE_ID(4'd3), .DEPTH(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] mk(input logic [3:0] dst, input logic [3:0] src,
                                     input logic [1:0] op, input logic [12:0] addr,
                                     input logic [15:0] data);
    return {dst, src, op, addr, data};
  endfunction

  // Count rising edges (sampled 1 time unit after) until the selected output
  // reaches v; sel 0=in_ack 1=out_req 2=busy.
  task automatic wait_for(input int sel, input logic v, output int n);
    logic cur;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      cur = (sel == 0) ? in_ack : (sel == 1) ? out_req : busy;
      if (cur === v) return;
    end
    check("wait_timeout", 64'd0, 64'd1);
  endtask

  // Full request handshake; caller is positioned 1 unit after a rising edge.
  task automatic do_req(input logic [38:0] p, input string tag);
    int n;
    in_data = p;
    in_req  = 1'b1;
    wait_for(0, 1'b1, n);
    check({tag, "_ack_rise_lat"}, 64'(n), 64'd3);
    in_req = 1'b0;
    wait_for(0, 1'b0, n);
    check({tag, "_ack_fall_lat"}, 64'(n), 64'd3);
  endtask

  // Request that produces no response: wait for return to IDLE.
  task automatic no_resp_req(input logic [38:0] p, input string tag);
    int n;
    do_req(p, tag);
    wait_for(2, 1'b0, n);
    check({tag, "_idle_lat"}, 64'(n), 64'd1);
    check({tag, "_no_out_req"}, 64'(out_req), 64'd0);
  endtask

  // Read request plus full response handshake.
  task automatic read_req(input logic [38:0] p, input logic [38:0] exp, input string tag);
    int n;
    do_req(p, tag);
    wait_for(1, 1'b1, n);
    check({tag, "_out_req_lat"}, 64'(n), 64'd1);
    check({tag, "_out_data"}, 64'(out_data), 64'(exp));
    out_ack = 1'b1;
    wait_for(1, 1'b0, n);
    check({tag, "_out_req_fall_lat"}, 64'(n), 64'd3);
    out_ack = 1'b0;
    wait_for(2, 1'b0, n);
    check({tag, "_idle_lat"}, 64'(n), 64'd3);
  endtask

  initial begin
    int n;
    int bad;
    logic [38:0] snap;

    rst_n   = 1'b0;
    in_req  = 1'b0;
    in_data = '0;
    out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ack",   64'(in_ack),   64'd0);
    check("rst_out_req",  64'(out_req),  64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_err_cnt",  64'(err_cnt),  64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read back
    no_resp_req(mk(4'd3, 4'd5, 2'b00, 13'h010, 16'hBEEF), "wr010");
    read_req(mk(4'd3, 4'd5, 2'b01, 13'h010, 16'h0000),
             {4'd5, 4'd3, 2'b10, 13'h010, 16'hBEEF}, "rd010");
    check("wr_rd_err_cnt", 64'(err_cnt), 64'd0);

    // Unwritten address reads as zero
    read_req(mk(4'd3, 4'd5, 2'b01, 13'h0FF, 16'h5555),
             {4'd5, 4'd3, 2'b10, 13'h0FF, 16'h0000}, "rd0ff");

    // Reject cases
    no_resp_req(mk(4'd7, 4'd5, 2'b00, 13'h020, 16'h1234), "rej_dst");
    check("rej_dst_err", 64'(err_cnt), 64'd1);
    read_req(mk(4'd3, 4'd2, 2'b01, 13'h020, 16'h0000),
             {4'd2, 4'd3, 2'b10, 13'h020, 16'h0000}, "rd020");
    no_resp_req(mk(4'd3, 4'd5, 2'b11, 13'h020, 16'h7777), "rej_op");
    check("rej_op_err", 64'(err_cnt), 64'd2);
    no_resp_req(mk(4'd3, 4'd5, 2'b01, 13'h100, 16'h0000), "rej_addr");
    check("rej_addr_err", 64'(err_cnt), 64'd3);
    read_req(mk(4'd3, 4'd1, 2'b01, 13'h010, 16'h0000),
             {4'd1, 4'd3, 2'b10, 13'h010, 16'hBEEF}, "rd010_after_rej");

    // Slow responder with a second request pending
    do_req(mk(4'd3, 4'd6, 2'b01, 13'h010, 16'h0000), "slow_rd");
    wait_for(1, 1'b1, n);
    check("slow_out_req_lat", 64'(n), 64'd1);
    snap = out_data;
    check("slow_out_data", 64'(snap), 64'({4'd6, 4'd3, 2'b10, 13'h010, 16'hBEEF}));
    in_data = mk(4'd3, 4'd6, 2'b00, 13'h030, 16'hCAFE);
    in_req  = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out_req !== 1'b1 || out_data !== snap || in_ack !== 1'b0) bad++;
    end
    check("slow_hold", 64'(bad), 64'd0);
    out_ack = 1'b1;
    wait_for(1, 1'b0, n);
    check("slow_out_req_fall_lat", 64'(n), 64'd3);
    out_ack = 1'b0;
    wait_for(0, 1'b1, n);
    check("slow_2nd_ack_lat", 64'(n), 64'd4);
    in_req = 1'b0;
    wait_for(0, 1'b0, n);
    check("slow_2nd_ack_fall_lat", 64'(n), 64'd3);
    wait_for(2, 1'b0, n);
    read_req(mk(4'd3, 4'd6, 2'b01, 13'h030, 16'h0000),
             {4'd6, 4'd3, 2'b10, 13'h030, 16'hCAFE}, "rd030");

    // Reset while in RESP
    do_req(mk(4'd3, 4'd4, 2'b01, 13'h030, 16'h0000), "rst_rd");
    wait_for(1, 1'b1, n);
    rst_n = 1'b0;
    #1;
    check("midrst_out_req", 64'(out_req), 64'd0);
    check("midrst_in_ack",  64'(in_ack),  64'd0);
    check("midrst_busy",    64'(busy),    64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    read_req(mk(4'd3, 4'd4, 2'b01, 13'h010, 16'h0000),
             {4'd4, 4'd3, 2'b10, 13'h010, 16'h0000}, "post_rst_rd010");
    read_req(mk(4'd3, 4'd4, 2'b01, 13'h030, 16'h0000),
             {4'd4, 4'd3, 2'b10, 13'h030, 16'h0000}, "post_rst_rd030");

    // Error counter saturation
    for (int i = 1; i <= 260; i++) begin
      no_resp_req(mk(4'd9, 4'd5, 2'b00, 13'h001, 16'hFFFF), "sat");
      if (i == 254) check("sat_254", 64'(err_cnt), 64'd254);
      if (i == 255) check("sat_255", 64'(err_cnt), 64'd255);
    end
    check("sat_260", 64'(err_cnt), 64'd255);
    no_resp_req(mk(4'd3, 4'd5, 2'b10, 13'h001, 16'h0000), "sat_more");
    check("sat_hold", 64'(err_cnt), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_noc_responder.md
# mem_noc_responder

Clocked memory-side NoC endpoint that terminates 39-bit request packets arriving over a 4-phase bundled-data channel. It serves write and read requests against a local 256x16 word store and returns read-response packets to the requesting node. It is the responder end of the packet protocol the memory wrappers initiate, and attaches to one NoC port (IN/OUT pair) in place of a wrapped behavioural memory.

## Interface
- NODE_ID, 4'd0, this endpoint's NoC address; packets with another dst are rejected.
- DEPTH, 256, words in local store; legal addr range 0..DEPTH-1 (DEPTH ≤ 8192).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_req  input  1  request-channel req, asynchronous to clk.
- in_data  input  39  request packet, bundled with in_req and stable while in_req=1.
- in_ack  output  1  request-channel ack.
- out_req  output  1  response-channel req.
- out_data  output  39  response packet, held stable from out_req rise until out_ack falls.
- out_ack  input  1  response-channel ack, asynchronous to clk.
- err_cnt  output  8  count of rejected packets, saturating at 255.
- busy  output  1  high whenever FSM is not IDLE.

## Operation
- Packet fields: [38:35] dst, [34:31] src, [30:29] op (00 write, 01 read, 10 read-response, 11 reserved), [28:16] addr, [15:0] data.
- in_req and out_ack each pass through a 2-flop synchronizer (in_req_s, out_ack_s); the FSM uses only the synchronized versions.
- The word store is a flop array cleared to 0 by reset.
- FSM states and transitions:
  - IDLE: on in_req_s=1, latch in_data into pkt, set in_ack=1, go to IN_REL.
  - IN_REL: on in_req_s=0, set in_ack=0, go to EXEC.
  - EXEC (1 cycle): classify pkt.
    - Reject if dst≠NODE_ID, op∈{10,11}, or addr≥DEPTH: err_cnt+1 (saturating), no store change, no response, go to IDLE.
    - Write: mem[addr]←data, go to IDLE.
    - Read: out_data←{src, NODE_ID, 2'b10, addr, mem[addr]}, out_req=1, go to RESP.
  - RESP: on out_ack_s=1, set out_req=0, go to RESP_REL.
  - RESP_REL: on out_ack_s=0, go to IDLE.
- The input handshake fully completes before any response is issued.
  - A new request is not acknowledged until the previous response handshake returns to zero.
  - Senders stall naturally; the block has no queue.
- Reset mid-operation: FSM goes to IDLE; the packet in flight is discarded and no response is sent.
  - If in_req is still high after reset release, it is treated as a new packet.

## Timing
- Reset values: in_ack=0, out_req=0, out_data=0, err_cnt=0, busy=0, synchronizers=0, store=0.
- in_req rises before edge k: in_ack=1 after edge k+2.
- in_req falls before edge m: in_ack=0 after edge m+2.
  - Action of EXEC at edge m+3.
  - For reads, out_req=1 and out_data valid after edge m+3.
  - For writes, the stored word is readable by the next request.
- out_ack rises before edge p: out_req=0 after edge p+2.
- out_ack falls before edge q: IDLE after edge q+2; a pending in_req is captured no earlier than edge q+3.
- out_data changes only in EXEC; it is never modified while out_req=1 or while waiting for out_ack to fall.
- Minimum request-to-request period (write, zero-delay sender): 6 cycles.
- busy=1 from the capture edge until the edge that re-enters IDLE.

## Test plan
- Write then read, NODE_ID=3.
  - Write pkt dst=3, src=5, op=00, addr=0x010, data=0xBEEF.
  - Read pkt dst=3, src=5, op=01, addr=0x010.
  - Expect out_data={5,3,2'b10,13'h010,16'hBEEF}, err_cnt=0.
- Read an unwritten address 0x0FF after reset -> response with data=0x0000.
- Reject cases, each with no store change, no out_req, and err_cnt incremented by 1 per packet (0→3):
  - dst=7 write of 0x1234 to addr 0x020; a subsequent valid read of 0x020 returns 0x0000.
  - op=11.
  - addr=0x100.
- Slow responder: hold out_ack low for 50 cycles after a read.
  - out_req stays 1 and out_data is constant.
  - A second in_req raised meanwhile is not acked until 3 edges after out_ack's low phase is seen.
  - The second request is then served correctly.
- Reset mid-handshake: assert rst_n=0 while in RESP.
  - out_req=0, in_ack=0, busy=0, err_cnt=0 immediately.
  - Earlier writes read back as 0.
- Saturation: 260 rejected packets -> err_cnt=255 and it stays there.
